// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the RC4 keystream generator
package rc4_pkg;
  localparam int SBOX_N  = 256;
  localparam int KEY_MAX = 32;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_KSA,
    ST_PRIME,
    ST_GEN
  } state_t;
endpackage

// File: rtl/rc4_keystream_gen_if.sv
// rtl/rc4_keystream_gen_if.sv - key load, restart and keystream handshake bundle
interface rc4_keystream_gen_if;
  import rc4_pkg::*;

  logic  key_valid;
  byte_t key_in;
  logic  ks_restart;
  logic  ks_ready;
  logic  ks_valid;
  byte_t ks_byte;
  logic  busy;

  modport master (
    output key_valid, key_in, ks_restart, ks_ready,
    input  ks_valid, ks_byte, busy
  );

  modport slave (
    input  key_valid, key_in, ks_restart, ks_ready,
    output ks_valid, ks_byte, busy
  );
endinterface

// File: rtl/rc4_sbox.sv
// rtl/rc4_sbox.sv - 256-entry S-box with identity init, two read ports and a swap write
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_init,
  input  logic  i_swap,
  input  byte_t i_addr_a,
  input  byte_t i_addr_b,
  input  byte_t i_addr_o,
  output byte_t o_rd_a,
  output byte_t o_rd_b,
  output byte_t o_rd_o
);
  byte_t r_mem [SBOX_N];

  assign o_rd_a = r_mem[i_addr_a];
  assign o_rd_b = r_mem[i_addr_b];

  // Output port sees the S-box as it will be after this cycle's swap.
  assign o_rd_o = (i_addr_o == i_addr_a) ? o_rd_b :
                  (i_addr_o == i_addr_b) ? o_rd_a : r_mem[i_addr_o];

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      for (int n = 0; n < SBOX_N; n++) begin
        r_mem[n[7:0]] <= n[7:0];
      end
    end else if (i_swap) begin
      r_mem[i_addr_a] <= o_rd_b;
      r_mem[i_addr_b] <= o_rd_a;
    end
  end
endmodule

// File: rtl/rc4_keystream_gen.sv
// rtl/rc4_keystream_gen.sv - RC4 key capture, key scheduling and one-byte-per-handshake keystream
module rc4_keystream_gen
  import rc4_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst,
  rc4_keystream_gen_if.slave bus
);
  state_t     r_state;
  byte_t      r_key [KEY_MAX];
  logic [5:0] r_key_len;
  logic [4:0] r_kidx;
  byte_t      r_i;
  byte_t      r_j;
  logic       r_ks_valid;
  byte_t      r_ks_byte;
  logic       r_busy;

  byte_t w_addr_a;
  byte_t w_addr_b;
  byte_t w_addr_o;
  byte_t w_rd_a;
  byte_t w_rd_b;
  byte_t w_rd_o;
  byte_t w_ksa_j;
  byte_t w_gen_j;
  logic  w_new_key;
  logic  w_restart;
  logic  w_step;
  logic  w_swap;
  logic  w_kidx_wrap;

  // A fresh key preempts everything except an ongoing load; restart needs a stored key.
  assign w_new_key   = bus.key_valid && (r_state != ST_LOAD);
  assign w_restart   = bus.ks_restart && (r_state != ST_LOAD) && (r_key_len != 6'd0);
  assign w_step      = (r_state == ST_PRIME) ||
                       ((r_state == ST_GEN) && r_ks_valid && bus.ks_ready);
  assign w_swap      = !i_rst && !w_new_key && !w_restart &&
                       ((r_state == ST_KSA) || w_step);
  assign w_kidx_wrap = ({1'b0, r_kidx} + 6'd1) == r_key_len;

  assign w_addr_a = (r_state == ST_KSA) ? r_i : r_i + 8'd1;
  assign w_ksa_j  = r_j + w_rd_a + r_key[r_kidx];
  assign w_gen_j  = r_j + w_rd_a;
  assign w_addr_b = (r_state == ST_KSA) ? w_ksa_j : w_gen_j;
  assign w_addr_o = w_rd_a + w_rd_b;

  rc4_sbox u_sbox (
    .i_clk    (i_clk),
    .i_init   (r_state == ST_INIT),
    .i_swap   (w_swap),
    .i_addr_a (w_addr_a),
    .i_addr_b (w_addr_b),
    .i_addr_o (w_addr_o),
    .o_rd_a   (w_rd_a),
    .o_rd_b   (w_rd_b),
    .o_rd_o   (w_rd_o)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_key_len  <= 6'd0;
      r_kidx     <= 5'd0;
      r_i        <= 8'd0;
      r_j        <= 8'd0;
      r_ks_valid <= 1'b0;
      r_ks_byte  <= 8'd0;
      r_busy     <= 1'b0;
    end else if (w_new_key) begin
      r_state    <= ST_LOAD;
      r_key[0]   <= bus.key_in;
      r_key_len  <= 6'd1;
      r_ks_valid <= 1'b0;
      r_busy     <= 1'b1;
    end else if (w_restart) begin
      r_state    <= ST_INIT;
      r_ks_valid <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (bus.key_valid) begin
            if (r_key_len < 6'(KEY_MAX)) begin
              r_key[r_key_len[4:0]] <= bus.key_in;
              r_key_len             <= r_key_len + 6'd1;
            end
          end else begin
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_i     <= 8'd0;
          r_j     <= 8'd0;
          r_kidx  <= 5'd0;
          r_state <= ST_KSA;
        end
        ST_KSA: begin
          r_kidx <= w_kidx_wrap ? 5'd0 : r_kidx + 5'd1;
          if (r_i == 8'hFF) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_state <= ST_PRIME;
          end else begin
            r_i <= r_i + 8'd1;
            r_j <= w_ksa_j;
          end
        end
        ST_PRIME, ST_GEN: begin
          if (w_step) begin
            r_i        <= w_addr_a;
            r_j        <= w_gen_j;
            r_ks_byte  <= w_rd_o;
            r_ks_valid <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_GEN;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ks_valid = r_ks_valid;
  assign bus.ks_byte  = r_ks_byte;
  assign bus.busy     = r_busy;
endmodule

// File: doc/rc4_keystream_gen.md
Name: rc4_keystream_gen

Overview:
Upstream stage of the RC4 stream datapath. Captures a 1..32-byte key on the key_valid/key_in strobe, runs the key-scheduling algorithm (KSA) over an internal 256-byte S-box, then produces one keystream byte per handshake. The downstream XOR/stream-control stage consumes these bytes for both plaintext→cipher and cipher→plaintext passes. ks_restart regenerates the identical keystream from the stored key for the decrypt pass.

Parameters:
KEY_MAX, 32, maximum key length in bytes; further bytes are ignored
SBOX_N, 256, S-box depth; fixed by the RC4 algorithm, not user-tunable

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
key_valid  input  1  high on consecutive cycles, one key byte per cycle
key_in  input  8  key byte, sampled when key_valid=1
ks_restart  input  1  one-cycle pulse: rerun init+KSA with the stored key
ks_ready  input  1  downstream accepts ks_byte this cycle
ks_valid  output  1  ks_byte holds a valid keystream byte
ks_byte  output  8  keystream byte
busy  output  1  high in LOAD/INIT/KSA/PRIME

Behaviour:
- Reset: state=IDLE, ks_valid=0, ks_byte=0, busy=0, key_len=0, i=j=0. S-box contents are don't-care until INIT.
- States: IDLE, LOAD, INIT, KSA, PRIME, GEN.
- IDLE/GEN + key_valid=1 → LOAD. Capture key_in into K[0] and set key_len=1. ks_valid drops on that edge. A new key aborts any operation in progress.
- LOAD: each key_valid=1 edge stores K[key_len] and increments key_len. key_len saturates at KEY_MAX; bytes beyond that are dropped without error.
- LOAD, first edge with key_valid=0 (E0) → INIT.
- INIT (1 cycle): S[n]=n for all n in parallel; i=0, j=0 → KSA.
- KSA: 256 iterations, one per cycle.
  - Per iteration: j = j + S[i] + K[i mod key_len] (mod 256); swap S[i], S[j]; i++.
  - After i=255 → PRIME with i=j=0.
- PRIME (1 cycle): compute the first PRGA byte.
  - ks_valid=1 is registered at edge E0+258.
  - busy falls at that same edge.
- PRGA step:
  - i' = i+1; j' = j + S[i']; swap S[i'], S[j'].
  - Output S[(S_old[i'] + S_old[j']) mod 256], read with post-swap forwarding: index==i' gives S_old[j'], index==j' gives S_old[i'].
  - Handles i'==j' correctly.
- GEN handshake:
  - On ks_valid && ks_ready, the next byte is computed and registered on the same edge. Throughput is 1 byte/cycle.
  - With ks_ready=0, ks_byte and all S/i/j state are frozen.
- ks_restart (any state except LOAD; ignored in LOAD):
  - → INIT on the next edge; ks_valid=0; stored K/key_len retained.
  - Keystream then restarts from byte 0.
- ks_restart with key_len=0 (no key ever loaded) is ignored.
- key_valid and ks_restart asserted together: key_valid wins.
- rst mid-KSA or mid-GEN: return to reset values next edge; key is lost.
- All arithmetic is 8-bit, wrapping mod 256. The key index counter wraps at key_len, not at a power of two.

Decomposition:
- rc4_pkg holds:
  - state enum (IDLE..GEN)
  - constants SBOX_N=256 and KEY_MAX=32
  - byte typedef
- One sub-module, rc4_sbox:
  - 256x8 register file
  - parallel identity-init
  - two combinational read ports plus a third forwarded output-read port
  - single-cycle swap write

Test Plan:
- Key "Key" (4B 65 79), ks_ready=1 → ks_valid at E0+258; bytes EB 9F 77 81 B7 34 CA 72 A7 19 on consecutive cycles.
- Key "Wiki" (57 69 6B 69) → 60 44 DB 6D 41 B7.
- Key "Secret" (53 65 63 72 65 74), ks_ready toggled 1,0,0,1,... → 04 D4 6B 05 3C A8 7B 59 in order; ks_byte stable while ks_ready=0, with no dup/skip.
- 40-byte key stream → key_len=32; output equals a reference model using the first 32 bytes.
- After 1000 bytes with key "Key", pulse ks_restart → busy for 258 cycles, then EB 9F 77 ... repeats; new key_valid mid-KSA → abort, output matches the new key.
- rst asserted for 1 cycle in GEN → ks_valid=0, busy=0, IDLE; ks_restart afterwards is ignored.
